// File: rtl/uart_out_pkg.sv
// uart_out_pkg: shared types and constants for the UART output port
package uart_out_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser with a valid/ready pop interface to the FIFO
// ports: clock, n_reset (async, active-low); valid/data = FIFO head; ready = pop strobe
//        when valid; tx = serial line (idle high); active = frame in progress
module uart_tx
    import uart_out_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  logic                   valid,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   ready,
    output logic                   tx,
    output logic                   active
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(UART_DATA_W);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(UART_DATA_W - 1);

    tx_state_t state;
    logic [BW-1:0] baud;
    logic [NW-1:0] bitn;
    logic [UART_DATA_W-1:0] shift;
    logic bit_end;

    assign bit_end = baud == LAST;
    // Popping on the last STOP cycle chains frames with no idle gap.
    assign ready = (state == IDLE) | ((state == STOP) & bit_end);
    assign active = state != IDLE;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            baud <= '0;
            bitn <= '0;
            shift <= '0;
            tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    if (valid) begin
                        state <= START;
                        shift <= data;
                        bitn <= '0;
                        tx <= 1'b0;
                    end
                end
                START: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        state <= DATA;
                        tx <= shift[0];
                    end
                end
                DATA: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        shift <= shift >> 1;
                        bitn <= bitn + 1'b1;
                        state <= (bitn == LAST_BIT) ? STOP : DATA;
                        tx <= (bitn == LAST_BIT) ? 1'b1 : shift[1];
                    end
                end
                default: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        state <= valid ? START : IDLE;
                        tx <= ~valid;
                        if (valid) begin
                            shift <= data;
                            bitn <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_out_port.sv
// uart_out_port: bus-snooping display port that queues STOREs and sends them as 8N1 UART frames
// ports: clock, n_reset (async, active-low); load_MAR/load_MDR/MDR_bus/CS/R_NW = bus controls;
//        sysbus = shared bus, listened to only; tx = serial out; busy/fifo_full/overflow = status
module uart_out_port
    import uart_out_pkg::*;
#(
    parameter int WORD_W       = 10,
    parameter int OP_W         = 3,
    parameter int PORT_ADDR    = 127,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              load_MAR,
    input  logic              load_MDR,
    input  logic              MDR_bus,
    input  logic              CS,
    input  logic              R_NW,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);
    localparam int AW = WORD_W - OP_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] PORT = AW'(PORT_ADDR);

    logic [AW-1:0] mar;
    logic [WORD_W-1:0] mdr, din;
    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic push, push_ok, pop, valid, ready, active;
    logic unused;

    assign sysbus = 'z;
    assign unused = ^{MDR_bus, din[WORD_W-1:UART_DATA_W]};
    // A STORE whose data arrives this very cycle bypasses the local mdr.
    assign din = load_MDR ? sysbus : mdr;
    assign push = CS & ~R_NW & (mar == PORT);
    assign valid = count != '0;
    assign pop = valid & ready;
    assign push_ok = push & (~fifo_full | pop);
    assign fifo_full = count == CW'(DEPTH);
    assign busy = active | valid;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din[UART_DATA_W-1:0];
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mar <= '0;
            mdr <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (load_MAR) mar <= sysbus[AW-1:0];
            if (load_MDR) mdr <= sysbus;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (push & ~push_ok) overflow <= 1'b1;
        end
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock  (clock),
        .n_reset(n_reset),
        .valid  (valid),
        .data   (mem[rd_ptr]),
        .ready  (ready),
        .tx     (tx),
        .active (active)
    );
endmodule
